// File: rtl/unidad_respuesta_ack.sv
// unidad_respuesta_ack
//   Processing-unit side of a start/ack return-to-zero handshake. A start
//   request captures two unsigned operands, an iterative shift-add multiplier
//   consumes one multiplier bit per clock (LSB first), and ack is raised with
//   the full-width product once all WIDTH bits have been processed.
//
// Ports
//   clk     in   clock, all state updates on the rising edge
//   reset   in   asynchronous active-low reset
//   start   in   level request, held high until ack is seen
//   op_a    in   WIDTH-bit unsigned multiplicand, sampled on the capture edge
//   op_b    in   WIDTH-bit unsigned multiplier, sampled on the capture edge
//   ack     out  completion flag, high only in DONE
//   busy    out  high only in BUSY
//   result  out  2*WIDTH-bit unsigned product, held until the next capture
module unidad_respuesta_ack #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 ack,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  // Partial-product accumulation for the current multiplier bit. The
  // accumulator is 2*WIDTH wide, so the sum can never overflow.
  function automatic logic [2*WIDTH-1:0] accum_step(
    input logic [2*WIDTH-1:0] acc,
    input logic [2*WIDTH-1:0] mcand,
    input logic               bit_set
  );
    accum_step = bit_set ? (acc + mcand) : acc;
  endfunction

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, op_a};
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = accum_step(acc_q, mcand_q, mplier_q[0]);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last bit: publish the finished product on the same edge DONE is
        // entered, so ack and result appear together.
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d = acc_d;
          state_d  = DONE;
        end
      end
      DONE: begin
        // Return-to-zero: start must be seen low before a new capture.
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Flags decode straight from the state register, so they are glitch-free
  // and mutually exclusive by construction.
  assign busy   = (state_q == BUSY);
  assign ack    = (state_q == DONE);
  assign result = result_q;

endmodule

// File: doc/unidad_respuesta_ack.md
UNIDAD_RESPUESTA_ACK -- requirements
Module: unidad_respuesta_ack

Purpose: processing-unit side of the start/ack flow-control handshake. It receives a start request, runs an iterative shift-add multiply, and returns ack.

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (reset=0 resets the block immediately, independent of clk).
REQ-004 start  input  1  level request from the flow controller; held high until ack is seen.
REQ-005 op_a  input  WIDTH  unsigned multiplicand; sampled only on the capture edge.
REQ-006 op_b  input  WIDTH  unsigned multiplier; sampled only on the capture edge.
REQ-007 ack  output  1  registered completion flag; high only in state DONE.
REQ-008 busy  output  1  registered; high only in state BUSY.
REQ-009 result  output  2*WIDTH  registered unsigned product op_a*op_b.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, BUSY and DONE, with encoding free.
REQ-011 In IDLE with start=1 sampled at edge k, the block SHALL capture op_a/op_b, clear the accumulator and bit counter, and enter BUSY at edge k.
REQ-012 In IDLE with start=0, the block SHALL hold all registers, including result.
REQ-013 In BUSY, each edge SHALL process one multiplier bit, LSB first:
- If the current bit=1, accumulator += shifted multiplicand.
- Multiplicand shifts left by 1; multiplier shifts right by 1; counter increments.
REQ-014 After exactly WIDTH BUSY iterations (edges k+1..k+WIDTH), the FSM SHALL enter DONE at edge k+WIDTH, with result = full 2*WIDTH product and ack=1 in the same cycle.
REQ-015 Arithmetic SHALL be unsigned, with the accumulator 2*WIDTH bits wide; overflow is impossible and no truncation is permitted.
REQ-016 The DONE to IDLE transition SHALL occur on the first edge where start=0 is sampled in DONE; ack=0 from that edge.
REQ-017 In DONE, ack SHALL stay high while start=1; a new operation SHALL NOT begin until start has been seen low (return-to-zero handshake).
REQ-018 start falling during BUSY SHALL be ignored; the computation completes and DONE is entered. If start is still 0 there, ack is high for exactly one cycle.
REQ-019 op_a/op_b changes after the capture edge SHALL NOT affect result.
REQ-020 result SHALL remain stable from DONE entry until the next capture edge.
REQ-021 busy and ack SHALL never be high simultaneously.
REQ-022 Latency from the capture edge to ack high SHALL be exactly WIDTH cycles; throughput SHALL be one operation per WIDTH+2 cycles minimum.

Reset
REQ-023 While reset=0, the block SHALL force state=IDLE, ack=0, busy=0, result=0, and clear accumulator, operand registers and counter.
REQ-024 Reset asserted during BUSY or DONE SHALL abort the operation with no ack pulse.
REQ-025 After reset releases, the first capture SHALL occur no earlier than the first rising edge with reset=1 and start=1.

Verification
REQ-026 Basic multiply, WIDTH=8, op_a=3, op_b=5: start held high -> busy high 8 cycles, then ack=1 with result=15; drop start -> ack=0 next edge.
REQ-027 Maximum operands, op_a=255, op_b=255 -> result=65025 (0xFE01) after 8 cycles; op_a=0, op_b=200 -> result=0 with the same latency.
REQ-028 Early start release, start high 1 cycle only, op_a=12, op_b=10 -> result=120, ack high exactly 1 cycle, then IDLE.
REQ-029 Start held high through DONE for 5 cycles -> ack stays high 5 cycles, busy stays 0, and no second capture occurs until start goes low then high.
REQ-030 Reset in BUSY, reset=0 at the 4th BUSY cycle of 7*9 -> ack/busy/result=0 immediately; after release with start=1, op_a=7, op_b=9 -> result=63 after 8 cycles.
REQ-031 Operand change after capture, op_a=6, op_b=7 captured, then op_a/op_b toggled randomly during BUSY -> result=42.
